req_arbiter8: RTL and testbench
===============================

# req_arbiter8

Eight-requester arbiter that shares one resource among requesters using a registered grant. Grant ownership is held until the owner drops its request, with an optional hold-time limit. Selection is fixed priority (bit 7 highest) or round-robin, chosen at run time. It sits in front of any shared datapath resource and drives a one-hot grant plus the encoded owner index.

## Interface
Parameters:
- MAX_HOLD, default 16: maximum consecutive cycles one owner keeps the grant while others wait; 0 disables the limit.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- mode  input  1  0 = fixed priority (index 7 highest), 1 = round-robin.
- req  input  8  request vector; bit i = requester i.
- grant  output  8  one-hot grant, registered; all zeros when nobody owns the resource.
- grant_valid  output  1  high when grant is nonzero.
- grant_id  output  3  binary index of the owner; 0 when grant_valid = 0.
- timeout  output  1  one-cycle pulse on the edge where an owner is pre-empted by the hold limit.

## Operation
- States:
  - IDLE: no owner.
  - BUSY: one owner, grant held.
- Arbitration event: occurs at an edge where any of the following holds:
  - the state is IDLE and req ≠ 0;
  - the state is BUSY and req[owner] = 0;
  - the state is BUSY and the hold limit expires.
- Arbitration procedure:
  - Candidates are the requesters with req = 1, excluding the current owner on release or pre-emption.
  - The winner becomes the owner and the state is BUSY.
  - With no candidates, the state becomes IDLE and all outputs go to 0.
- Fixed priority: the highest set candidate index wins.
- Round-robin:
  - A pointer P holds the index of the most recent winner.
  - Search order is P-1, P-2, …, 0, 7, …, P, wrapping modulo 8.
  - P updates to the winner on every grant.
  - P resets to 0, so the first search order is 7..0, identical to fixed priority.
- mode is sampled only at arbitration events; changing it while BUSY does not disturb the current owner.
- Lock:
  - While BUSY with req[owner] = 1 and the hold limit not reached, grant is unchanged.
  - Higher-priority requests do not pre-empt the owner.
- Requests are not latched: a requester that deasserts req before winning is forgotten.
- Hold counter:
  - Width is clog2(MAX_HOLD+1).
  - It clears to 0 on each grant edge and increments on each edge while the owner keeps its grant.
  - Expiry: counter = MAX_HOLD-1, req[owner] = 1, and at least one other req bit is set. The next edge re-arbitrates excluding the owner and pulses timeout.
  - If no other requester is pending, the owner keeps the grant, the counter saturates at MAX_HOLD-1, and there is no timeout.
  - MAX_HOLD = 0: the counter is unused and timeout stays 0.
- grant_id and grant_valid are registered alongside grant and always consistent with it.

## Timing
- Reset values: grant = 0, grant_valid = 0, grant_id = 0, timeout = 0, state IDLE, P = 0, counter = 0.
- rst_n assertion mid-grant clears all outputs immediately, without waiting for a clock edge.
- Latency: req sampled at edge t appears as grant after edge t (one cycle).
- Release: the owner drops req before edge t; the next winner's grant is visible after edge t. There is no idle bubble and grant is never zero between back-to-back owners.
- Release and a new request in the same cycle: the new request is a candidate at that edge.
- Pre-emption: the owner holds exactly MAX_HOLD cycles. timeout is high for the single cycle in which the new grant first appears.
- Owner drops req on the same edge the limit would expire: treated as a normal release, timeout = 0.
- Only one grant bit is ever high; grant changes only at clock edges.

## Test plan
- Fixed priority and back-to-back hand-off:
  - mode = 0, req = 8'b0010_0100 before edge t → grant = 8'b0010_0000, grant_id = 5 after t.
  - Drop req[5] before edge t+3 → grant = 8'b0000_0100, grant_id = 2 after t+3, with no zero cycle between.
- Round-robin rotation: mode = 1, req = 8'hFF, each owner drops its req for one cycle after holding 2 cycles → grant_id sequence 7, 6, 5, 4, 3, 2, 1, 0, 7.
- Hold-limit pre-emption: MAX_HOLD = 16, mode = 0, req[0] granted and held, req[3] raised during the grant → req[0] holds 16 cycles, then grant = 8'b0000_1000 with timeout high for exactly that first cycle.
- Lone owner past the limit: MAX_HOLD = 16, only req[0] high for 40 cycles → grant = 8'b0000_0001 throughout, timeout never asserts.
- Async reset mid-grant: rst_n low while grant = 8'b0100_0000 → all outputs 0 before the next edge. After release with mode = 1 and req = 8'b1000_0001, the first grant goes to index 7.
- Idle and vanished requester: req = 0 for 10 cycles → grant_valid = 0 and grant_id = 0. A one-cycle req[4] pulse while req[6] owns → req[4] is never granted after req[6] releases.

Source files
------------

// File: rtl/req_arbiter8.sv
// req_arbiter8: eight-way arbiter with registered one-hot grant,
// fixed-priority or round-robin selection, and an optional hold limit.
module req_arbiter8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic       grant_valid,
  output logic [2:0] grant_id,
  output logic       timeout
);

  localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int LIMI = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
  localparam logic [CW-1:0] LIM = CW'(LIMI);
  localparam logic HOLD_EN = (MAX_HOLD > 0);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]    state;
  logic [2:0]    ptr;
  logic [CW-1:0] cnt;

  logic          busy;
  logic          held;
  logic          others;
  logic          expire;
  logic          arb;
  logic [7:0]    cand;
  logic [2:0]    base;
  logic [2:0]    idx;
  logic [2:0]    win;
  logic          win_ok;

  assign busy   = (state == BUSY);
  assign held   = busy && req[grant_id];
  assign others = |(req & ~grant);
  assign expire = HOLD_EN && held && (cnt == LIM) && others;
  assign arb    = (!busy && (|req)) || (busy && !req[grant_id]) || expire;
  assign cand   = req & ~grant;

  // Fixed priority is round-robin with the pointer pinned at 0.
  assign base = mode ? ptr : 3'd0;

  always_comb begin
    win_ok = 1'b0;
    win    = 3'd0;
    idx    = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      idx = base - 3'(k);
      if (!win_ok && cand[idx]) begin
        win_ok = 1'b1;
        win    = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= 3'd0;
      cnt         <= '0;
      grant       <= 8'd0;
      grant_valid <= 1'b0;
      grant_id    <= 3'd0;
      timeout     <= 1'b0;
    end else if (arb) begin
      cnt <= '0;
      if (win_ok) begin
        state       <= BUSY;
        ptr         <= win;
        grant       <= 8'b1 << win;
        grant_valid <= 1'b1;
        grant_id    <= win;
        timeout     <= expire;
      end else begin
        state       <= IDLE;
        grant       <= 8'd0;
        grant_valid <= 1'b0;
        grant_id    <= 3'd0;
        timeout     <= 1'b0;
      end
    end else begin
      timeout <= 1'b0;
      if (busy && HOLD_EN && cnt != LIM)
        cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_req_arbiter8.sv
// tb_req_arbiter8: directed checks of priority, round-robin,
// hold-limit pre-emption and async reset for req_arbiter8.
module tb_req_arbiter8;

  logic       clk;
  logic       rst_n;
  logic       mode;
  logic [7:0] req;
  logic [7:0] grant;
  logic       grant_valid;
  logic [2:0] grant_id;
  logic       timeout;

  int n_assert;
  int n_fail;

  req_arbiter8 #(.MAX_HOLD(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mode(mode),
    .req(req),
    .grant(grant),
    .grant_valid(grant_valid),
    .grant_id(grant_id),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [7:0] g,
                           input logic v, input logic [2:0] id,
                           input logic to);
    check({tag, ".grant"}, grant, g);
    check({tag, ".valid"}, {7'd0, grant_valid}, {7'd0, v});
    check({tag, ".id"}, {5'd0, grant_id}, {5'd0, id});
    check({tag, ".timeout"}, {7'd0, timeout}, {7'd0, to});
  endtask

  initial begin
    logic [7:0] one;
    int cur;
    int exp_ids [8];
    one = 8'h01;
    n_assert = 0;
    n_fail = 0;
    rst_n = 1'b0;
    mode = 1'b0;
    req = 8'd0;
    #3;
    check_out("reset", 8'h00, 1'b0, 3'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_out("reset_idle", 8'h00, 1'b0, 3'd0, 1'b0);

    // fixed priority and back-to-back hand-off
    req = 8'b0010_0100;
    tick();
    check_out("fp_first", 8'h20, 1'b1, 3'd5, 1'b0);
    tick();
    check("fp_lock1", grant, 8'h20);
    tick();
    check("fp_lock2", grant, 8'h20);
    req = 8'b0000_0100;
    tick();
    check_out("fp_handoff", 8'h04, 1'b1, 3'd2, 1'b0);

    // idle
    req = 8'd0;
    tick();
    check("idle_first", grant, 8'h00);
    repeat (10) tick();
    check_out("idle_long", 8'h00, 1'b0, 3'd0, 1'b0);

    // vanished requester
    req = 8'b0100_0000;
    tick();
    check_out("van_own6", 8'h40, 1'b1, 3'd6, 1'b0);
    req = 8'b0101_0000;
    tick();
    check("van_lock", grant, 8'h40);
    req = 8'b0100_0000;
    tick();
    tick();
    check("van_still6", grant, 8'h40);
    req = 8'd0;
    tick();
    check_out("van_release", 8'h00, 1'b0, 3'd0, 1'b0);
    tick();
    check("van_never4", grant, 8'h00);

    // hold-limit pre-emption
    req = 8'h01;
    tick();
    check_out("hl_own0", 8'h01, 1'b1, 3'd0, 1'b0);
    req = 8'h09;
    for (int i = 0; i < 15; i++) begin
      tick();
      check("hl_hold", grant, 8'h01);
      check("hl_noto", {7'd0, timeout}, 8'h00);
    end
    tick();
    check_out("hl_preempt", 8'h08, 1'b1, 3'd3, 1'b1);
    tick();
    check_out("hl_after", 8'h08, 1'b1, 3'd3, 1'b0);
    req = 8'd0;
    tick();
    check("hl_idle", grant, 8'h00);

    // lone owner past the limit
    req = 8'h01;
    for (int i = 0; i < 40; i++) begin
      tick();
      check("lone_grant", grant, 8'h01);
      check("lone_noto", {7'd0, timeout}, 8'h00);
    end
    req = 8'd0;
    tick();

    // async reset mid-grant
    req = 8'b0100_0000;
    tick();
    check("ar_own6", grant, 8'h40);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("ar_cleared", 8'h00, 1'b0, 3'd0, 1'b0);
    mode = 1'b1;
    req = 8'b1000_0001;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_out("ar_rr_first", 8'h80, 1'b1, 3'd7, 1'b0);

    // round-robin rotation
    exp_ids = '{6, 5, 4, 3, 2, 1, 0, 7};
    cur = 7;
    req = 8'hFF;
    tick();
    check("rr_hold7", {5'd0, grant_id}, 8'd7);
    for (int i = 0; i < 8; i++) begin
      req = 8'hFF & ~(one << cur);
      tick();
      check("rr_next", {5'd0, grant_id}, 8'(exp_ids[i]));
      check("rr_onehot", grant, one << exp_ids[i]);
      cur = exp_ids[i];
      req = 8'hFF;
      tick();
      check("rr_hold", {5'd0, grant_id}, 8'(exp_ids[i]));
    end
    req = 8'd0;
    tick();
    check_out("rr_idle", 8'h00, 1'b0, 3'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
